// File: rtl/and_gate_tester.sv
// Exhaustive stimulus generator and checker for an N-input AND gate.
// Walks x through every vector in ascending order, samples z after a settle window and tallies mismatches.
module and_gate_tester #(
  parameter int N      = 2,
  parameter int SETTLE = 1
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         start,
  input  logic         z,
  output logic [N-1:0] x,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_count,
  output logic [N-1:0] fail_vec,
  output logic         fail_valid
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0]   SETTLE_C = 4'(SETTLE);
  localparam logic [N-1:0] ALL_ONES = '1;

  state_t       state_q;
  logic [3:0]   cnt_q;
  logic [N-1:0] x_q;
  logic         busy_q;
  logic         done_q;
  logic         pass_q;
  logic [N:0]   err_q;
  logic [N-1:0] fail_vec_q;
  logic         fail_valid_q;

  logic         exp_z;
  logic         mismatch;
  logic [N:0]   err_d;

  // An unknown or floating z never matches the truth table, so it is counted as a failure.
  always_comb begin
    exp_z    = &x_q;
    mismatch = (z === exp_z) ? 1'b0 : 1'b1;
    err_d    = err_q + (N+1)'(mismatch);
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      x_q          <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
      fail_vec_q   <= '0;
      fail_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q      <= RUN;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            fail_vec_q   <= '0;
            fail_valid_q <= 1'b0;
            x_q          <= '0;
            cnt_q        <= SETTLE_C;
          end
        end
        RUN: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            err_q <= err_d;
            if (mismatch && !fail_valid_q) begin
              fail_vec_q   <= x_q;
              fail_valid_q <= 1'b1;
            end
            // The all-ones vector is the last one; x never wraps within a run.
            if (x_q == ALL_ONES) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              x_q     <= '0;
              pass_q  <= (err_d == '0);
            end else begin
              x_q   <= x_q + 1'b1;
              cnt_q <= SETTLE_C;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign x          = x_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_vec   = fail_vec_q;
  assign fail_valid = fail_valid_q;

endmodule

// File: tb/tb_and_gate_tester.sv
// Directed bench for and_gate_tester: three instances (N2/S1, N2/S0, N3/S2) driven by modelled gates,
// with per-cycle expectations queued at start and popped as the run advances.
module tb_and_gate_tester;

  logic clock = 1'b0;
  logic reset_;
  always #5 clock = ~clock;

  logic       start0, start1, start2;
  logic       z0, z1, z2;
  logic [1:0] x0, x1;
  logic [2:0] x2;
  logic       busy0, busy1, busy2, done0, done1, done2, pass0, pass1, pass2;
  logic [2:0] err0, err1;
  logic [3:0] err2;
  logic [1:0] fv0, fv1;
  logic [2:0] fv2;
  logic       fl0, fl1, fl2;
  int         mode0, mode1, mode2;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int x; int busy; int done; int pass; int err; int fvec; int fval;
  } exp_t;
  exp_t sb[$];

  // Gate model: 0 = AND, 1 = OR, 2 = stuck at 0, 3 = stuck at 1
  function automatic logic gate(input int mode, input int v, input int n);
    case (mode)
      0:       return (v == (1 << n) - 1);
      1:       return (v != 0);
      2:       return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  assign z0 = gate(mode0, int'(x0), 2);
  assign z1 = gate(mode1, int'(x1), 2);
  assign z2 = gate(mode2, int'(x2), 3);

  and_gate_tester #(.N(2), .SETTLE(1)) dut0 (
    .clock(clock), .reset_(reset_), .start(start0), .z(z0), .x(x0), .busy(busy0),
    .done(done0), .pass(pass0), .err_count(err0), .fail_vec(fv0), .fail_valid(fl0));
  and_gate_tester #(.N(2), .SETTLE(0)) dut1 (
    .clock(clock), .reset_(reset_), .start(start1), .z(z1), .x(x1), .busy(busy1),
    .done(done1), .pass(pass1), .err_count(err1), .fail_vec(fv1), .fail_valid(fl1));
  and_gate_tester #(.N(3), .SETTLE(2)) dut2 (
    .clock(clock), .reset_(reset_), .start(start2), .z(z2), .x(x2), .busy(busy2),
    .done(done2), .pass(pass2), .err_count(err2), .fail_vec(fv2), .fail_valid(fl2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic get_obs(input int inst, output exp_t o, output logic [31:0] ox);
    case (inst)
      0: begin ox = 32'(x0); o.busy = busy0; o.done = done0; o.pass = pass0;
               o.err = int'(err0); o.fvec = int'(fv0); o.fval = fl0; end
      1: begin ox = 32'(x1); o.busy = busy1; o.done = done1; o.pass = pass1;
               o.err = int'(err1); o.fvec = int'(fv1); o.fval = fl1; end
      default: begin ox = 32'(x2); o.busy = busy2; o.done = done2; o.pass = pass2;
               o.err = int'(err2); o.fvec = int'(fv2); o.fval = fl2; end
    endcase
    o.x = int'(ox);
  endtask

  task automatic set_start(input int inst, input logic v);
    case (inst)
      0: start0 = v;
      1: start1 = v;
      default: start2 = v;
    endcase
  endtask

  // Expected state after each edge k+j of a run, then the DONE state.
  task automatic push_run(input int n, input int s, input int mode);
    int total;
    int all;
    exp_t e;
    total = (1 << n) * (s + 1);
    all   = (1 << n) - 1;
    for (int j = 0; j <= total; j++) begin
      e.err = 0; e.fvec = 0; e.fval = 0;
      for (int v = 0; v <= all && (v + 1) * (s + 1) <= j; v++) begin
        if (gate(mode, v, n) != (v == all)) begin
          e.err++;
          if (e.fval == 0) begin e.fvec = v; e.fval = 1; end
        end
      end
      if (j < total) begin
        e.x = j / (s + 1); e.busy = 1; e.done = 0; e.pass = 0;
      end else begin
        e.x = 0; e.busy = 0; e.done = 1; e.pass = (e.err == 0) ? 1 : 0;
      end
      sb.push_back(e);
    end
  endtask

  task automatic check_all(input string tag, input int inst, input exp_t e);
    exp_t o;
    logic [31:0] ox;
    get_obs(inst, o, ox);
    check({tag, ".x"},      ox,           32'(e.x));
    check({tag, ".busy"},   32'(o.busy),  32'(e.busy));
    check({tag, ".done"},   32'(o.done),  32'(e.done));
    check({tag, ".pass"},   32'(o.pass),  32'(e.pass));
    check({tag, ".err"},    32'(o.err),   32'(e.err));
    check({tag, ".fvec"},   32'(o.fvec),  32'(e.fvec));
    check({tag, ".fvalid"}, 32'(o.fval),  32'(e.fval));
  endtask

  // Pulse start (re-pulsed at edge k+rep when rep > 0) and pop one expectation per edge.
  task automatic run(input string name, input int inst, input int n, input int s,
                     input int mode, input int rep);
    int j;
    @(negedge clock);
    set_start(inst, 1'b1);
    push_run(n, s, mode);
    j = 0;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      @(posedge clock);
      #1;
      check_all($sformatf("%s[k+%0d]", name, j), inst, e);
      if (j == 0) set_start(inst, 1'b0);
      if (rep > 0 && j + 1 == rep) set_start(inst, 1'b1);
      if (rep > 0 && j == rep) set_start(inst, 1'b0);
      j++;
    end
  endtask

  initial begin
    exp_t zero;
    zero = '{x: 0, busy: 0, done: 0, pass: 0, err: 0, fvec: 0, fval: 0};
    reset_ = 1'b0;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    mode0 = 0; mode1 = 2; mode2 = 0;
    #12;
    check_all("reset0", 0, zero);
    check_all("reset2", 2, zero);
    @(negedge clock);
    reset_ = 1'b1;

    // Correct AND, with a start re-pulse during the run that must be ignored
    run("and_n2s1", 0, 2, 1, 0, 3);

    // OR gate, then restart from DONE with identical results
    @(negedge clock);
    mode0 = 1;
    run("or_n2s1", 0, 2, 1, 1, 0);
    run("or_restart", 0, 2, 1, 1, 0);

    // Stuck-at faults with no settle window
    run("stuck0_n2s0", 1, 2, 0, 2, 0);
    mode1 = 3;
    run("stuck1_n2s0", 1, 2, 0, 3, 0);

    // Asynchronous reset while x=10
    mode0 = 0;
    @(negedge clock);
    start0 = 1'b1;
    @(posedge clock);
    #1;
    start0 = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    check("midrun.x", 32'(x0), 32'd2);
    #2;
    reset_ = 1'b0;
    #1;
    check_all("async_reset", 0, zero);
    @(negedge clock);
    reset_ = 1'b1;
    run("after_reset", 0, 2, 1, 0, 0);

    // Three-input AND with a longer settle window
    run("and_n3s2", 2, 3, 2, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/and_gate_tester.md
Name: and_gate_tester

Overview:
Sequential stimulus generator and checker that sits on the other side of an N-input AND gate (the gate under test).
- Drives every input combination onto the gate's inputs in ascending binary order.
- Samples the gate output after a settle window and compares it against the AND truth table.
- Reports mismatch count, first failing vector and an overall pass/fail flag.
- Used as the self-checking harness for the gate-level AND blocks in the lab sequence.

Parameters:
N, 2, number of gate inputs driven (1..8)
SETTLE, 1, extra clock cycles each vector is held before z is sampled (0..15)

Ports:
clock  input  1  system clock, all state updates on rising edge
reset_  input  1  asynchronous active-low reset
start  input  1  request to run a full test; accepted only in IDLE or DONE
z  input  1  output of the gate under test
x  output  N  stimulus vector driven to the gate inputs (x[N-1] is MSB)
busy  output  1  high while a test run is in progress
done  output  1  high in DONE state, results valid
pass  output  1  valid when done=1; 1 iff err_count==0
err_count  output  N+1  number of mismatching vectors in the current/last run
fail_vec  output  N  first vector that mismatched
fail_valid  output  1  1 once fail_vec holds a captured vector

Behaviour:
Interface:
- One clock `clock`.
- Reset `reset_` is asynchronous and active-low.
- While reset_=0, all outputs are 0: x, busy, done, pass, err_count, fail_vec, fail_valid. State is IDLE and the settle counter is 0.
- Reset asserted mid-run aborts the run immediately, with no partial result retained.

FSM states: IDLE, RUN, DONE. All outputs are registered.

IDLE/DONE with start=1 at edge k:
- state<=RUN, busy<=1, done<=0, pass<=0.
- err_count<=0, fail_valid<=0, fail_vec<=0.
- x<=0, cnt<=SETTLE.

IDLE/DONE with start=0: hold all outputs.

RUN, each edge:
- If cnt!=0: cnt<=cnt-1, x held.
- If cnt==0: sample z; expected = &x (1 only for all-ones).
  - Mismatch (z!=expected, X/Z on z counts as mismatch): err_count<=err_count+1; if fail_valid==0, fail_vec<=x and fail_valid<=1.
  - If x==all-ones: state<=DONE, busy<=0, done<=1, x<=0, pass<=1 iff the final err_count (including this sample) is 0.
  - Otherwise x<=x+1, cnt<=SETTLE.

Timing and limits:
- start is ignored while busy=1.
- Each vector is held SETTLE+1 cycles and sampled on the last edge of its window.
- done rises at edge k + 2^N*(SETTLE+1).
- err_count max is 2^N, which fits N+1 bits, so there is no wrap.
- x never wraps past all-ones within a run.

DONE:
- done, pass, err_count, fail_vec and fail_valid are held until the next accepted start or reset.
- start in DONE restarts immediately; the clearing of results in the restart edge takes priority.

Test Plan:
1. N=2, SETTLE=1, correct AND on z, start pulsed 1 cycle at edge k -> x sequence 00,00,01,01,10,10,11,11; done=1 and busy=0 at edge k+8; pass=1, err_count=0, fail_valid=0, x=00.
2. N=2, SETTLE=1, OR gate on z -> mismatches at 01 and 10; done at k+8; err_count=2, fail_vec=01, fail_valid=1, pass=0.
3. N=2, SETTLE=0, z stuck at 0 -> only 11 fails; done at k+4; err_count=1, fail_vec=11, pass=0. With z stuck at 1 instead -> err_count=3, fail_vec=00.
4. start re-pulsed at edge k+3 during run 1 -> ignored; done still at k+8. Then start again in DONE -> results cleared on that edge, new run completes 8 cycles later with identical results.
5. reset_ dropped asynchronously mid-cycle during RUN at x=10 -> all outputs 0 without waiting for a clock edge. After release, start runs a clean full sequence.
6. N=3, SETTLE=2, correct 3-input AND -> 8 vectors x 3 cycles, done at k+24, pass=1, err_count=0 (4-bit).
